// File: rtl/ls27_pin_tester.sv
// ---------------------------------------------------------------------------
// ls27_pin_tester
//
// Exerciser for a triple 3-input NOR package. It sweeps every combination of
// the nine gate inputs, waits a programmable settle time per vector, and
// compares each of the three gate outputs against the expected NOR. At the end
// of a sweep it reports pass/fail, which gates failed, how many vectors failed
// and the index of the first failing vector.
//
// Parameters:
//   SETTLE_CYCLES - cycles each vector is held before sampling (>= 3, to cover
//                   the 2-flop synchronizer plus margin)
//   ERR_W         - width of o_err_count (>= 10 so 512 failures fit)
//
// Ports:
//   clk              in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   i_start          in   begin a sweep; only looked at while idle
//   o_a1..o_c3       out  drive pins to the gate inputs (registered from vec)
//   i_y1..i_y3       in   gate outputs, asynchronous to clk
//   o_busy           out  sweep in progress
//   o_done           out  sweep finished; held until the next accepted start
//   o_pass           out  valid with o_done: no mismatch on any vector
//   o_fail_mask      out  bit k-1 set if gate k mismatched on any vector
//   o_err_count      out  number of vectors with at least one mismatch
//   o_first_fail_vec out  vector index of the first mismatching vector
// ---------------------------------------------------------------------------
module ls27_pin_tester #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    output logic             o_a1,
    output logic             o_b1,
    output logic             o_c1,
    output logic             o_a2,
    output logic             o_b2,
    output logic             o_c2,
    output logic             o_a3,
    output logic             o_b3,
    output logic             o_c3,
    input  logic             i_y1,
    input  logic             i_y2,
    input  logic             i_y3,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [2:0]       o_fail_mask,
    output logic [ERR_W-1:0] o_err_count,
    output logic [8:0]       o_first_fail_vec
);

    localparam int CNT_W = ($clog2(SETTLE_CYCLES) > 0) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2
    } state_t;

    state_t           r_state;
    logic [8:0]       r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [2:0]       r_fail_mask;
    logic [ERR_W-1:0] r_err_count;
    logic [8:0]       r_first_fail_vec;

    logic [2:0]       w_exp;
    logic [2:0]       w_mism;

    // Expected output of gate k+1 is the NOR of its three pins, taken from
    // the vector currently being driven.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_exp
            assign w_exp[gi] = ~(|r_vec[3*gi +: 3]);
        end
    endgenerate

    // Only the second synchronizer stage is compared; the first may be
    // metastable when a gate output changes near a clock edge.
    assign w_mism = r_sync2 ^ w_exp;

    // Pins come straight from the vector register, so they are glitch-free.
    assign o_a1 = r_vec[0];
    assign o_b1 = r_vec[1];
    assign o_c1 = r_vec[2];
    assign o_a2 = r_vec[3];
    assign o_b2 = r_vec[4];
    assign o_c2 = r_vec[5];
    assign o_a3 = r_vec[6];
    assign o_b3 = r_vec[7];
    assign o_c3 = r_vec[8];

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_fail_mask      = r_fail_mask;
    assign o_err_count      = r_err_count;
    assign o_first_fail_vec = r_first_fail_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_vec            <= '0;
            r_cnt            <= '0;
            r_sync1          <= '0;
            r_sync2          <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_fail_mask      <= '0;
            r_err_count      <= '0;
            r_first_fail_vec <= '0;
        end else begin
            r_sync1 <= {i_y3, i_y2, i_y1};
            r_sync2 <= r_sync1;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_vec            <= '0;
                        r_cnt            <= '0;
                        r_fail_mask      <= '0;
                        r_err_count      <= '0;
                        r_first_fail_vec <= '0;
                        r_done           <= 1'b0;
                        r_pass           <= 1'b0;
                        r_busy           <= 1'b1;
                        r_state          <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_CHECK: begin
                    r_fail_mask <= r_fail_mask | w_mism;
                    if (|w_mism) begin
                        r_err_count <= r_err_count + ERR_W'(1);
                        // First failure: the count is still zero before
                        // this vector's increment lands.
                        if (r_err_count == '0) begin
                            r_first_fail_vec <= r_vec;
                        end
                    end
                    if (r_vec == 9'h1FF) begin
                        // Last vector: pins stay at 511 until next start.
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_mism == 3'b000) && (r_err_count == '0);
                        r_state <= S_IDLE;
                    end else begin
                        r_vec   <= r_vec + 9'd1;
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ls27_pin_tester.sv
module tb_ls27_pin_tester;

    localparam int SWEEP_CYCLES = 512 * 5;
    localparam int MAX_WAIT     = 3000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       a1, b1, c1, a2, b2, c2, a3, b3, c3;
    logic       y1, y2, y3;
    logic       busy, done, pass;
    logic [2:0] fail_mask;
    logic [9:0] err_count;
    logic [8:0] first_fail_vec;
    logic [8:0] pins;

    // 0: good NOR, 1: y2 stuck-at-0, 2: y3 stuck-at-1, 3: y1 acts as OR
    logic [1:0] fault_mode = 2'd0;

    int n_checks = 0;
    int n_fail   = 0;

    assign pins = {c3, b3, a3, c2, b2, a2, c1, b1, a1};

    // Gate model with 10 ns propagation delay
    assign #10 y1 = (fault_mode == 2'd3) ? (a1 | b1 | c1) : ~(a1 | b1 | c1);
    assign #10 y2 = (fault_mode == 2'd1) ? 1'b0 : ~(a2 | b2 | c2);
    assign #10 y3 = (fault_mode == 2'd2) ? 1'b1 : ~(a3 | b3 | c3);

    always #5 clk = ~clk;

    ls27_pin_tester #(
        .SETTLE_CYCLES(4),
        .ERR_W(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_start(start),
        .o_a1(a1), .o_b1(b1), .o_c1(c1),
        .o_a2(a2), .o_b2(b2), .o_c2(c2),
        .o_a3(a3), .o_b3(b3), .o_c3(c3),
        .i_y1(y1), .i_y2(y2), .i_y3(y3),
        .o_busy(busy),
        .o_done(done),
        .o_pass(pass),
        .o_fail_mask(fail_mask),
        .o_err_count(err_count),
        .o_first_fail_vec(first_fail_vec)
    );

    // One-cycle start pulse; returns at the negedge after the sampling edge.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done is seen (bounded); also counts cycles where
    // busy was low before done appeared.
    task automatic wait_done(output int cycles, output int busy_gaps);
        cycles    = 0;
        busy_gaps = 0;
        while (cycles < MAX_WAIT) begin
            @(negedge clk);
            cycles++;
            if (done) break;
            if (!busy) busy_gaps++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, pass} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 000", {busy, done, pass});
        end
        n_checks++;
        if ({fail_mask, err_count, first_fail_vec} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_results: got mask=%b err=%0d first=%0h required 0",
                     fail_mask, err_count, first_fail_vec);
        end
        n_checks++;
        if (pins !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_pins: got %0h required 0", pins);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: busy got %b required 0", busy);
        end
        $display("test_reset: done");
    endtask

    task automatic test_pass_sweep();
        int cycles, gaps;
        fault_mode = 2'd0;
        pulse_start();
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL pass_start: busy/done got %b required 10", {busy, done});
        end
        wait_done(cycles, gaps);
        n_checks++;
        if (cycles !== SWEEP_CYCLES) begin
            n_fail++;
            $display("FAIL pass_latency: got %0d cycles required %0d", cycles, SWEEP_CYCLES);
        end
        n_checks++;
        if (gaps !== 0) begin
            n_fail++;
            $display("FAIL pass_busy: busy low for %0d cycles required 0", gaps);
        end
        n_checks++;
        if ({busy, done, pass} !== 3'b011) begin
            n_fail++;
            $display("FAIL pass_flags: got %b required 011", {busy, done, pass});
        end
        n_checks++;
        if ({fail_mask, err_count, first_fail_vec} !== 22'd0) begin
            n_fail++;
            $display("FAIL pass_results: got mask=%b err=%0d first=%0h required 0",
                     fail_mask, err_count, first_fail_vec);
        end
        n_checks++;
        if (pins !== 9'h1FF) begin
            n_fail++;
            $display("FAIL pass_pins_hold: got %0h required 1ff", pins);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done, pass} !== 2'b11) begin
            n_fail++;
            $display("FAIL pass_done_held: got %b required 11", {done, pass});
        end
        $display("test_pass_sweep: cycles=%0d pass=%b err=%0d", cycles, pass, err_count);
    endtask

    task automatic test_y2_stuck0();
        int cycles, gaps;
        fault_mode = 2'd1;
        pulse_start();
        wait_done(cycles, gaps);
        n_checks++;
        if (cycles !== SWEEP_CYCLES) begin
            n_fail++;
            $display("FAIL y2s0_latency: got %0d required %0d", cycles, SWEEP_CYCLES);
        end
        n_checks++;
        if (err_count !== 10'd64) begin
            n_fail++;
            $display("FAIL y2s0_err: got %0d required 64", err_count);
        end
        n_checks++;
        if (fail_mask !== 3'b010) begin
            n_fail++;
            $display("FAIL y2s0_mask: got %b required 010", fail_mask);
        end
        n_checks++;
        if (first_fail_vec !== 9'h000) begin
            n_fail++;
            $display("FAIL y2s0_first: got %0h required 0", first_fail_vec);
        end
        n_checks++;
        if ({done, pass} !== 2'b10) begin
            n_fail++;
            $display("FAIL y2s0_pass: done/pass got %b required 10", {done, pass});
        end
        $display("test_y2_stuck0: err=%0d mask=%b first=%0h", err_count, fail_mask, first_fail_vec);
    endtask

    task automatic test_y3_stuck1();
        int cycles, gaps;
        fault_mode = 2'd2;
        pulse_start();
        wait_done(cycles, gaps);
        n_checks++;
        if (err_count !== 10'd448) begin
            n_fail++;
            $display("FAIL y3s1_err: got %0d required 448", err_count);
        end
        n_checks++;
        if (fail_mask !== 3'b100) begin
            n_fail++;
            $display("FAIL y3s1_mask: got %b required 100", fail_mask);
        end
        n_checks++;
        if (first_fail_vec !== 9'h040) begin
            n_fail++;
            $display("FAIL y3s1_first: got %0h required 40", first_fail_vec);
        end
        n_checks++;
        if ({done, pass} !== 2'b10) begin
            n_fail++;
            $display("FAIL y3s1_pass: done/pass got %b required 10", {done, pass});
        end
        $display("test_y3_stuck1: err=%0d mask=%b first=%0h", err_count, fail_mask, first_fail_vec);
    endtask

    task automatic test_y1_or();
        int cycles, gaps;
        fault_mode = 2'd3;
        pulse_start();
        wait_done(cycles, gaps);
        n_checks++;
        if (err_count !== 10'd512) begin
            n_fail++;
            $display("FAIL y1or_err: got %0d required 512", err_count);
        end
        n_checks++;
        if (fail_mask !== 3'b001) begin
            n_fail++;
            $display("FAIL y1or_mask: got %b required 001", fail_mask);
        end
        n_checks++;
        if (first_fail_vec !== 9'h000) begin
            n_fail++;
            $display("FAIL y1or_first: got %0h required 0", first_fail_vec);
        end
        $display("test_y1_or: err=%0d mask=%b first=%0h", err_count, fail_mask, first_fail_vec);
    endtask

    task automatic test_reset_mid_sweep();
        int cycles, gaps;
        fault_mode = 2'd0;
        pulse_start();
        // Vector index advances every 5 cycles: after 502 edges vec = 100.
        repeat (502) @(negedge clk);
        n_checks++;
        if (pins !== 9'd100) begin
            n_fail++;
            $display("FAIL mid_pins: got %0d required 100", pins);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, pass, fail_mask, err_count, first_fail_vec, pins} !== 34'd0) begin
            n_fail++;
            $display("FAIL mid_async_reset: busy=%b done=%b pass=%b mask=%b err=%0d first=%0h pins=%0h required all 0",
                     busy, done, pass, fail_mask, err_count, first_fail_vec, pins);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, pins} !== 10'd0) begin
            n_fail++;
            $display("FAIL mid_no_resume: busy=%b pins=%0h required 0", busy, pins);
        end
        pulse_start();
        wait_done(cycles, gaps);
        n_checks++;
        if (cycles !== SWEEP_CYCLES) begin
            n_fail++;
            $display("FAIL after_reset_latency: got %0d required %0d", cycles, SWEEP_CYCLES);
        end
        n_checks++;
        if ({done, pass, err_count} !== {2'b11, 10'd0}) begin
            n_fail++;
            $display("FAIL after_reset_pass: done=%b pass=%b err=%0d required 1 1 0", done, pass, err_count);
        end
        $display("test_reset_mid_sweep: cycles=%0d pass=%b", cycles, pass);
    endtask

    task automatic test_back_to_back();
        int cycles, gaps;
        fault_mode = 2'd1;
        pulse_start();
        cycles = 0;
        while (cycles < MAX_WAIT) begin
            @(negedge clk);
            cycles++;
            if (cycles == 700 || cycles == 1500) start = 1'b1;
            else if (cycles == 701 || cycles == 1501) start = 1'b0;
            else if (cycles == 2400) start = 1'b1;   // held through done
            if (done) break;
        end
        n_checks++;
        if (cycles !== SWEEP_CYCLES) begin
            n_fail++;
            $display("FAIL b2b_ignore_start: got %0d cycles required %0d", cycles, SWEEP_CYCLES);
        end
        n_checks++;
        if ({fail_mask, err_count} !== {3'b010, 10'd64}) begin
            n_fail++;
            $display("FAIL b2b_first_results: mask=%b err=%0d required 010 64", fail_mask, err_count);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_restart: busy/done got %b required 10", {busy, done});
        end
        n_checks++;
        if ({fail_mask, err_count, pins} !== 22'd0) begin
            n_fail++;
            $display("FAIL b2b_cleared: mask=%b err=%0d pins=%0h required 0", fail_mask, err_count, pins);
        end
        wait_done(cycles, gaps);
        n_checks++;
        if (cycles !== SWEEP_CYCLES) begin
            n_fail++;
            $display("FAIL b2b_second_latency: got %0d required %0d", cycles, SWEEP_CYCLES);
        end
        n_checks++;
        if ({pass, err_count, first_fail_vec} !== {1'b0, 10'd64, 9'd0}) begin
            n_fail++;
            $display("FAIL b2b_second_results: pass=%b err=%0d first=%0h required 0 64 0",
                     pass, err_count, first_fail_vec);
        end
        $display("test_back_to_back: second sweep err=%0d", err_count);
    endtask

    initial begin
        test_reset();
        test_pass_sweep();
        test_y2_stuck0();
        test_y3_stuck1();
        test_y1_or();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
